maxpool2x2_stage: RTL and testbench
===================================

Name: maxpool2x2_stage

Overview:
- Streaming multi-channel 2x2, stride-2 max-pool stage for the CNN layer chain.
- Sits between convolution layers and consumes their packed multi-channel pixel stream, e.g. the 8-channel output of the first-part convolution pair.
- Halves width and height; all channels are processed in parallel.
- One line buffer holds the horizontal maxima of the top row of each pooling window.

Parameters:
- DATA_WIDHT, 32: bits per channel sample, signed two's complement.
- CH, 8: channel count packed per pixel.
- IMG_WIDTH, 44: input image width in pixels, >= 2.
- IMG_HEIGHT, 44: input image height in pixels, >= 2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- Data_In  in  DATA_WIDHT*CH  input pixel; channel c occupies bits [c*DATA_WIDHT +: DATA_WIDHT].
- Valid_In  in  1  Data_In valid this cycle.
- Data_Out  out  DATA_WIDHT*CH  pooled pixel, same packing as Data_In.
- Valid_Out  out  1  Data_Out valid; one-cycle pulse per output pixel.
- Frame_Done  out  1  one-cycle pulse marking the end of an input frame.

Behaviour:
- Reset (rst=0, asynchronous): col=0, row=0, Valid_Out=0, Frame_Done=0, Data_Out=0, hold register cleared. Line buffer contents are not reset.
- Input order: raster, row-major. One pixel is accepted per cycle in which Valid_In=1. Idle gaps of any length are allowed, and state is held during gaps.
- Counters:
  - col advances 0..IMG_WIDTH-1, then wraps to 0 and row increments.
  - row wraps 0 after IMG_HEIGHT-1.
  - The next frame follows with no dead cycle.
- Even col (col[0]=0, col < 2*(IMG_WIDTH/2)): latch Data_In into the hold register.
- Odd col: hmax = per-channel signed max(hold, Data_In).
  - Even row: write hmax to linebuf[col>>1].
  - Odd row: out = per-channel signed max(linebuf[col>>1], hmax). Register out to Data_Out and set Valid_Out=1 on the next edge.
- Latency: Valid_Out rises exactly 1 cycle after the bottom-right pixel of each window is accepted.
- Data_Out holds its last value while Valid_Out=0.
- Odd dimensions: a trailing odd column or row is accepted and counted but contributes to no output (floor behaviour). Outputs per frame = (IMG_WIDTH/2)*(IMG_HEIGHT/2).
- Frame_Done: pulses 1 cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted. It may coincide with the final Valid_Out.
- Signed max: ties return either operand (the values are equal). Comparison is a full-width signed compare, with no saturation or rounding.
- Reset mid-frame: the partial frame is discarded and no Valid_Out is produced for it. The next pixel accepted after reset is treated as (0,0).
- Line buffer: depth IMG_WIDTH/2, width DATA_WIDHT*CH. Synchronous write; read address = col>>1, combinational or registered so that the 1-cycle latency holds.
- Storage: line buffer plus hold register only; no backpressure input.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: each output channel is clamped to 0 if negative before it is registered; latency is unchanged.
- Undefined: raw signed max is output.

Decomposition:
- Shared package/include holds:
  - a clog2 constant function;
  - localparams OUT_W = IMG_WIDTH/2, OUT_H = IMG_HEIGHT/2, LB_DEPTH = OUT_W;
  - PIX_W = DATA_WIDHT*CH;
  - counter widths derived via clog2.
- One sub-module, pool_line_buf: a single-port-write/single-read memory with parameters depth and width. The per-channel max is a generate loop in the top level.

Test Plan:
1. W=H=4, CH=2, contiguous Valid_In; ch0 = row*4+col, ch1 = -(row*4+col). Required outputs:
   - ch0 = 5, 7, 13, 15;
   - ch1 = 0, -2, -8, -10;
   - 4 Valid_Out pulses, Frame_Done once;
   - with POOL_RELU_EN, ch1 = 0, 0, 0, 0.
2. Same frame with Valid_In asserted every other cycle: identical data, and each Valid_Out is exactly 1 cycle after the corresponding odd-row/odd-col pixel.
3. W=H=5, ramp ch0 = row*5+col: 25 pixels give exactly 4 outputs (6, 8, 16, 18), and Frame_Done follows pixel 24.
4. Two back-to-back W=H=4 frames, second frame ramp +100: outputs 5, 7, 13, 15, then 105, 107, 113, 115, with two Frame_Done pulses.
5. Assert rst low after 6 pixels, release, then send a full W=H=4 ramp: no output from the partial frame, then 5, 7, 13, 15.
6. Signed extremes in one window (0x80000000, 0x7FFFFFFF, 0xFFFFFFFF, 0x00000000): output 0x7FFFFFFF. All-0x80000000 window gives 0x80000000, or 0 with POOL_RELU_EN.

Source files
------------

// File: rtl/maxpool2x2_stage_pkg.sv
// Shared definitions for the 2x2 stride-2 max-pool stage.
//   - default geometry of the pooling stage (matches the CNN chain)
//   - clog2: constant function for counter and address widths
//   - out_dim: pooled dimension (floor of half the input dimension)
package maxpool2x2_stage_pkg;

   localparam int DEF_DATA_WIDHT = 32;
   localparam int DEF_CH         = 8;
   localparam int DEF_IMG_WIDTH  = 44;
   localparam int DEF_IMG_HEIGHT = 44;

   localparam int DEF_OUT_W    = DEF_IMG_WIDTH / 2;
   localparam int DEF_OUT_H    = DEF_IMG_HEIGHT / 2;
   localparam int DEF_LB_DEPTH = DEF_OUT_W;
   localparam int DEF_PIX_W    = DEF_DATA_WIDHT * DEF_CH;

   // Never returns less than 1 so a depth-1 memory still gets an address bit.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

   function automatic int out_dim(input int in_dim);
      return in_dim / 2;
   endfunction

endpackage

// File: rtl/maxpool2x2_stage_pool_line_buf.sv
// pool_line_buf: line buffer holding the horizontal maxima of the top row
// of each pooling window.
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  read data, combinational from rd_addr
// Contents are deliberately not reset.
module pool_line_buf
   import maxpool2x2_stage_pkg::*;
#(
   parameter int DEPTH = DEF_LB_DEPTH,
   parameter int WIDTH = DEF_PIX_W
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic [clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]        rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/maxpool2x2_stage.sv
// maxpool2x2_stage: streaming multi-channel 2x2 stride-2 max-pool.
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   Data_In     in   input pixel, channel c at [c*DATA_WIDHT +: DATA_WIDHT]
//   Valid_In    in   Data_In valid this cycle
//   Data_Out    out  pooled pixel, same packing; held while Valid_Out=0
//   Valid_Out   out  one-cycle pulse per pooled pixel
//   Frame_Done  out  one-cycle pulse after the last pixel of a frame
// Optional macro POOL_RELU_EN: clamp negative output channels to 0.
module maxpool2x2_stage
   import maxpool2x2_stage_pkg::*;
#(
   parameter int DATA_WIDHT = DEF_DATA_WIDHT,
   parameter int CH         = DEF_CH,
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDHT*CH-1:0]   Data_In,
   input  logic                       Valid_In,
   output logic [DATA_WIDHT*CH-1:0]   Data_Out,
   output logic                       Valid_Out,
   output logic                       Frame_Done
);

   localparam int OUT_W    = out_dim(IMG_WIDTH);
   localparam int LB_DEPTH = OUT_W;
   localparam int PIX_W    = DATA_WIDHT * CH;
   localparam int COL_W    = clog2(IMG_WIDTH);
   localparam int ROW_W    = clog2(IMG_HEIGHT);
   localparam int LB_AW    = clog2(LB_DEPTH);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam bit               W_ODD    = (IMG_WIDTH % 2) == 1;

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [PIX_W-1:0] hold_q, hold_d;
   logic [PIX_W-1:0] data_out_q, data_out_d;
   logic             valid_out_q, valid_out_d;
   logic             frame_done_q, frame_done_d;

   logic [PIX_W-1:0] hmax;
   logic [PIX_W-1:0] pool_out;
   logic [PIX_W-1:0] lb_rd_data;
   logic [LB_AW-1:0] lb_addr;
   logic             lb_wr_en;
   logic             col_last, row_last;
   logic             accept_even, accept_odd;

   assign lb_addr = LB_AW'(col_q >> 1);

   pool_line_buf #(
      .DEPTH (LB_DEPTH),
      .WIDTH (PIX_W)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (lb_wr_en),
      .wr_addr (lb_addr),
      .wr_data (hmax),
      .rd_addr (lb_addr),
      .rd_data (lb_rd_data)
   );

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [DATA_WIDHT-1:0] hold_s, in_s, lb_s, hmax_s, max_s;

      assign hold_s = hold_q[c*DATA_WIDHT +: DATA_WIDHT];
      assign in_s   = Data_In[c*DATA_WIDHT +: DATA_WIDHT];
      assign lb_s   = lb_rd_data[c*DATA_WIDHT +: DATA_WIDHT];
      assign hmax_s = (in_s > hold_s) ? in_s : hold_s;
      assign max_s  = (lb_s > hmax_s) ? lb_s : hmax_s;

      assign hmax[c*DATA_WIDHT +: DATA_WIDHT] = hmax_s;
`ifdef POOL_RELU_EN
      assign pool_out[c*DATA_WIDHT +: DATA_WIDHT] = max_s[DATA_WIDHT-1] ? '0 : max_s;
`else
      assign pool_out[c*DATA_WIDHT +: DATA_WIDHT] = max_s;
`endif
   end

   always_comb begin
      col_last     = (col_q == COL_LAST);
      row_last     = (row_q == ROW_LAST);
      // A trailing column of an odd-width image is counted but never pooled.
      accept_even  = Valid_In && !col_q[0] && !(W_ODD && col_last);
      accept_odd   = Valid_In && col_q[0];
      lb_wr_en     = accept_odd && !row_q[0];

      col_d        = col_q;
      row_d        = row_q;
      if (Valid_In) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      hold_d       = accept_even ? Data_In : hold_q;
      // Odd columns only exist inside a full window, and odd rows likewise,
      // so no extra bound check is needed here.
      valid_out_d  = accept_odd && row_q[0];
      data_out_d   = valid_out_d ? pool_out : data_out_q;
      frame_done_d = Valid_In && col_last && row_last;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         data_out_q   <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign Data_Out   = data_out_q;
   assign Valid_Out  = valid_out_q;
   assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stage.sv
module tb_maxpool2x2_stage;

   localparam int DW = 32;
   localparam int CH = 2;
   localparam int PW = DW * CH;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [PW-1:0] din4 = '0, din5 = '0;
   logic          vin4 = 1'b0, vin5 = 1'b0;
   logic [PW-1:0] dout4, dout5;
   logic          vo4, vo5, fd4, fd5;

   always #5 clk = ~clk;

   maxpool2x2_stage #(.DATA_WIDHT(DW), .CH(CH), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .Data_In    (din4),
      .Valid_In   (vin4),
      .Data_Out   (dout4),
      .Valid_Out  (vo4),
      .Frame_Done (fd4)
   );

   maxpool2x2_stage #(.DATA_WIDHT(DW), .CH(CH), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u_dut5 (
      .clk        (clk),
      .rst        (rst),
      .Data_In    (din5),
      .Valid_In   (vin5),
      .Data_Out   (dout5),
      .Valid_Out  (vo5),
      .Frame_Done (fd5)
   );

   int            checks = 0;
   int            errors = 0;
   logic [PW-1:0] q4[$];
   logic [PW-1:0] q5[$];
   logic [PW-1:0] last4 = '0, last5 = '0;
   int            r4 = 0, c4 = 0, r5 = 0, c5 = 0;

   typedef struct {
      logic [31:0] a0[4];
      logic [31:0] a1[4];
      logic [31:0] e0;
      logic [31:0] e1;
   } win_t;

   win_t tbl[4];

   task automatic chk(input bit ok, input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef POOL_RELU_EN
      return x[31] ? 32'd0 : x;
`else
      return x;
`endif
   endfunction

   function automatic logic [PW-1:0] ev(input logic [31:0] e0, input logic [31:0] e1);
      return {relu(e1), relu(e0)};
   endfunction

   function automatic logic [PW-1:0] rnd();
      return {$urandom, $urandom};
   endfunction

   // One clock: drive inputs, advance the bench's raster model, then compare
   // the registered outputs 1 time unit after the edge.
   task automatic step(input bit v4, input logic [PW-1:0] d4, input bit v5, input logic [PW-1:0] d5);
      bit            nvo4, nfd4, nvo5, nfd5;
      logic [PW-1:0] e;
      vin4 = v4; din4 = d4;
      vin5 = v5; din5 = d5;
      nvo4 = v4 && (c4 % 2 == 1) && (r4 % 2 == 1);
      nfd4 = v4 && (c4 == 3) && (r4 == 3);
      if (v4) begin
         if (c4 == 3) begin c4 = 0; r4 = (r4 == 3) ? 0 : r4 + 1; end
         else c4++;
      end
      nvo5 = v5 && (c5 % 2 == 1) && (r5 % 2 == 1);
      nfd5 = v5 && (c5 == 4) && (r5 == 4);
      if (v5) begin
         if (c5 == 4) begin c5 = 0; r5 = (r5 == 4) ? 0 : r5 + 1; end
         else c5++;
      end
      @(posedge clk);
      #1;
      chk(vo4 == nvo4, "valid_out4", PW'(vo4), PW'(nvo4));
      chk(fd4 == nfd4, "frame_done4", PW'(fd4), PW'(nfd4));
      if (nvo4) begin
         if (q4.size() == 0) chk(1'b0, "scoreboard4_empty", dout4, '0);
         else begin
            e = q4.pop_front();
            chk(dout4 == e, "data_out4", dout4, e);
            last4 = e;
         end
      end else begin
         chk(dout4 == last4, "hold4", dout4, last4);
      end
      chk(vo5 == nvo5, "valid_out5", PW'(vo5), PW'(nvo5));
      chk(fd5 == nfd5, "frame_done5", PW'(fd5), PW'(nfd5));
      if (nvo5) begin
         if (q5.size() == 0) chk(1'b0, "scoreboard5_empty", dout5, '0);
         else begin
            e = q5.pop_front();
            chk(dout5 == e, "data_out5", dout5, e);
            last5 = e;
         end
      end else begin
         chk(dout5 == last5, "hold5", dout5, last5);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, rnd(), 1'b0, rnd());
   endtask

   // W=H=4 ramp: ch0 = base + r*4 + c, ch1 = -(base + r*4 + c).
   task automatic send4_ramp(input int base, input bit gaps);
      int v;
      q4.push_back(ev(32'(base + 5),  32'(-(base + 0))));
      q4.push_back(ev(32'(base + 7),  32'(-(base + 2))));
      q4.push_back(ev(32'(base + 13), 32'(-(base + 8))));
      q4.push_back(ev(32'(base + 15), 32'(-(base + 10))));
      for (int i = 0; i < 16; i++) begin
         v = base + i;
         step(1'b1, {32'(-v), 32'(v)}, 1'b0, rnd());
         if (gaps) idle(1);
      end
   endtask

   initial begin
      logic [31:0] f0[16];
      logic [31:0] f1[16];
      int          k, j, v;

      tbl[0].a0 = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      tbl[0].a1 = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000005, 32'h00000002};
      tbl[0].e0 = 32'h7FFFFFFF;  tbl[0].e1 = 32'h00000005;
      tbl[1].a0 = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
      tbl[1].a1 = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
      tbl[1].e0 = 32'h80000000;  tbl[1].e1 = 32'h80000000;
      tbl[2].a0 = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};
      tbl[2].a1 = '{32'h00000001, 32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF};
      tbl[2].e0 = 32'hFFFFFFFF;  tbl[2].e1 = 32'h7FFFFFFF;
      tbl[3].a0 = '{32'h00000003, 32'hFFFFFFFB, 32'h00000007, 32'h00000007};
      tbl[3].a1 = '{32'h00000009, 32'h00000000, 32'h00000000, 32'h00000001};
      tbl[3].e0 = 32'h00000007;  tbl[3].e1 = 32'h00000009;

      // Reset state
      #12;
      chk(vo4 == 1'b0, "reset_valid_out4", PW'(vo4), '0);
      chk(fd4 == 1'b0, "reset_frame_done4", PW'(fd4), '0);
      chk(dout4 == '0, "reset_data_out4", dout4, '0);
      chk(vo5 == 1'b0, "reset_valid_out5", PW'(vo5), '0);
      chk(fd5 == 1'b0, "reset_frame_done5", PW'(fd5), '0);
      chk(dout5 == '0, "reset_data_out5", dout5, '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(2);

      // Contiguous ramp frame
      send4_ramp(0, 1'b0);
      idle(3);

      // Same frame with a bubble after every pixel
      send4_ramp(0, 1'b1);
      idle(3);

      // Two frames back to back
      send4_ramp(0, 1'b0);
      send4_ramp(100, 1'b0);
      idle(3);

      // Odd 5x5 frame: trailing row and column are dropped
      q5.push_back(ev(32'd6, 32'd0));
      q5.push_back(ev(32'd8, 32'd0));
      q5.push_back(ev(32'd16, 32'd0));
      q5.push_back(ev(32'd18, 32'd0));
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            step(1'b0, rnd(), 1'b1, {32'd0, 32'(r * 5 + c)});
      idle(3);

      // Signed extremes, one table record per pooling window
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            k = (r / 2) * 2 + c / 2;
            j = (r % 2) * 2 + c % 2;
            f0[r * 4 + c] = tbl[k].a0[j];
            f1[r * 4 + c] = tbl[k].a1[j];
         end
      end
      for (int i = 0; i < 4; i++) q4.push_back(ev(tbl[i].e0, tbl[i].e1));
      for (int i = 0; i < 16; i++) step(1'b1, {f1[i], f0[i]}, 1'b0, rnd());
      idle(3);

      // Reset mid-frame: the window-completing 6th pixel is killed by reset
      for (int i = 0; i < 5; i++) step(1'b1, {32'(-i), 32'(i)}, 1'b0, rnd());
      vin4 = 1'b1;
      v    = 5;
      din4 = {32'(-v), 32'(v)};
      #3;
      rst = 1'b0;
      #1;
      chk(vo4 == 1'b0, "midreset_valid_out4", PW'(vo4), '0);
      chk(dout4 == '0, "midreset_data_out4", dout4, '0);
      chk(dout5 == '0, "midreset_data_out5", dout5, '0);
      @(posedge clk);
      #1;
      chk(vo4 == 1'b0, "midreset_no_output", PW'(vo4), '0);
      vin4 = 1'b0;
      rst  = 1'b1;
      r4 = 0; c4 = 0; r5 = 0; c5 = 0;
      last4 = '0; last5 = '0;
      q4.delete();
      idle(3);
      send4_ramp(0, 1'b0);
      idle(3);

      chk(q4.size() == 0, "scoreboard4_drained", PW'(q4.size()), '0);
      chk(q5.size() == 0, "scoreboard5_drained", PW'(q5.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
